freq_bcd_converter: RTL and testbench
=====================================

// Module: freq_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3) between the colour-frequency select mux and the 4-digit seven-segment driver.
//  Takes one captured binary frequency per request and returns packed BCD digits after a fixed latency.
//  Out-of-range values saturate, and a flag reports the saturation.
// PARAMETERS
//  BIN_W   16  width of bin_in; also the number of shift iterations
//  DIGITS  4   BCD digits produced; MAX_VAL = 10^DIGITS-1 (9999)
// PORTS
//  CLK100MHZ  in   1           system clock, all logic on rising edge
//  reset      in   1           synchronous, active-high
//  start      in   1           request conversion of bin_in (level sampled each cycle)
//  bin_in     in   BIN_W       binary frequency value
//  busy       out  1           high while a conversion is in progress
//  done       out  1           1-cycle pulse: bcd_out/overflow updated this cycle
//  bcd_out    out  4*DIGITS    packed BCD, digit 0 in [3:0]
//  overflow   out  1           last result was saturated
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, bcd_out=0, overflow=0, shift/count regs cleared. Reset mid-conversion aborts immediately, and no done pulse is produced.
//  - FSM states:
//    - IDLE: on start=1, capture bin_in, clamp to MAX_VAL, latch overflow_next=(bin_in>MAX_VAL), load scratch BCD=0, count=0, go to CONV.
//    - CONV: each cycle, add 3 to every scratch digit >=5, then shift {scratch,bin} left by 1 and increment count. After BIN_W iterations, go to DONE.
//    - DONE: one cycle. done=1, bcd_out<=scratch, overflow<=overflow_next. If start=1, capture and go to CONV (back-to-back); else go to IDLE.
//  - Latency: start sampled at edge N -> done=1 and bcd_out valid at edge N+BIN_W+1 (17 cycles at default).
//  - busy=1 in CONV only; busy=0 in IDLE and DONE. Throughput: one result per BIN_W+1 cycles.
//  - start while in CONV is ignored and not queued. bin_in is don't-care except in the capture cycle.
//  - bcd_out and overflow hold their last values between done pulses and never show intermediate scratch data.
//  - Arithmetic: the scratch register is 4*DIGITS bits. The add-3 adjust is applied before each shift, including the first. Since clamped input <= MAX_VAL, no digit exceeds 9 after the final shift.
//  - bin_in=0 -> 0x0000. bin_in=MAX_VAL -> 0x9999 with overflow=0. bin_in=MAX_VAL+1 -> 0x9999 with overflow=1.
// CONFIGURATION
//  - Macro BCD_BLANK_EN defined: extra output blank_mask [DIGITS-1:0], registered and updated with bcd_out on done.
//    - Bit i=1 when digit i and all higher digits are 0.
//    - Bit 0 is always 0, so a value of 0 shows "0".
//    - Reset value is {DIGITS-1{1'b1},1'b0}.
//  - Macro undefined: port and logic absent; the display shows leading zeros.
// STRUCTURE
//  - Shared package freq_disp_pkg:
//    - localparams ST_IDLE, ST_CONV, ST_DONE (2-bit encoding);
//    - BCD_DIGIT_W=4 and ADD3_THRESH=5;
//    - function max_val(DIGITS), returning 10^DIGITS-1.
//  - Sub-module bcd_digit_adj: combinational 4-bit in/out, out = in>=5 ? in+3 : in. Instantiated DIGITS times via generate.
//  - Counter width is $clog2(BIN_W+1).
// TESTING
//  1. Assert reset 2 cycles -> busy=0, done=0, bcd_out=16'h0000, overflow=0 (blank_mask=4'b1110 with BCD_BLANK_EN).
//  2. bin_in=1234, start 1 cycle -> busy=1 for 16 cycles, done pulse at cycle 17, bcd_out=16'h1234, overflow=0.
//  3. bin_in=2047 (max 11-bit display value) -> bcd_out=16'h2047. Then bin_in=0 -> bcd_out=16'h0000.
//  4. bin_in=12000 -> bcd_out=16'h9999, overflow=1. Next bin_in=9999 -> 16'h9999, overflow=0.
//  5. start held with bin_in=5 at capture, then changed to 42 during CONV -> one result 16'h0005. start=1 in the DONE cycle with bin_in=42 -> next result 16'h0042 after 17 more cycles with no IDLE gap.
//  6. Reset asserted in the 8th CONV cycle -> next cycle busy=0, bcd_out=0, and no done pulse. With BCD_BLANK_EN, bin_in=7 -> blank_mask=4'b1110; bin_in=305 -> blank_mask=4'b1000.

Source files
------------

// File: rtl/freq_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_disp_pkg
// Description : Shared constants, state encoding and helpers for the
//               frequency display path (binary-to-BCD conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package freq_disp_pkg;

  // Width of one packed BCD digit and the shift-and-add-3 threshold.
  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Converter state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_DONE = ST_DONE
  } conv_state_e;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage : freq_disp_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Single-digit add-3 adjust of the double-dabble algorithm.
//               Any digit >= 5 gets 3 added so that the following left
//               shift carries correctly into the next decimal digit.
// Ports       : digit_i  - current scratch digit
//               digit_o  - adjusted digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import freq_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  localparam logic [BCD_DIGIT_W-1:0] C_THRESH = BCD_DIGIT_W'(ADD3_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] C_ADD    = BCD_DIGIT_W'(3);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= C_THRESH) begin
      digit_o = digit_i + C_ADD;
    end
  end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/freq_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : freq_bcd_converter
// Description : Sequential shift-and-add-3 binary-to-BCD converter. One
//               binary value is captured per request, clamped to the largest
//               DIGITS-digit decimal value, and converted in BIN_W cycles.
//               The result appears with a one-cycle done pulse; saturation
//               is reported on overflow.
// Ports       : CLK100MHZ  - system clock (rising edge)
//               reset      - synchronous active-high reset
//               start      - conversion request (level, sampled each cycle)
//               bin_in     - binary input value
//               busy       - conversion in progress
//               done       - bcd_out/overflow updated this cycle
//               bcd_out    - packed BCD result, digit 0 in [3:0]
//               overflow   - last result was saturated
//               blank_mask - (BCD_BLANK_EN only) leading-zero blanking mask
// Config      : define BCD_BLANK_EN to add the blank_mask output.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_bcd_converter
  import freq_disp_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank_mask
`endif
);

  localparam int          SW      = BCD_DIGIT_W * DIGITS;
  localparam int          CW      = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = max_val(DIGITS);

  conv_state_e       state_q, state_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_scr_shift;
  logic [BIN_W-1:0]  w_bin_shift;
  logic              w_unused_msb;
  logic              w_last;
  logic              w_ovf_in;
  logic [BIN_W-1:0]  w_clamped;

  // Add-3 adjust on every scratch digit before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Shift {adjusted scratch, binary} left by one. The scratch MSB falls off;
  // it is always zero because the clamped input never exceeds MAX_VAL.
  assign {w_unused_msb, w_scr_shift, w_bin_shift} = {w_adj, bin_q, 1'b0};

  assign w_last    = (count_q == CW'(BIN_W - 1));
  assign w_ovf_in  = (32'(bin_in) > MAX_VAL);
  assign w_clamped = w_ovf_in ? BIN_W'(MAX_VAL) : bin_in;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] w_blank;

  // A digit blanks only when it and every more-significant digit are zero;
  // digit 0 never blanks so that zero still displays as "0".
  always_comb begin
    w_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (i == DIGITS - 1) begin
        w_blank[i] = (w_scr_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      end else begin
        w_blank[i] = w_blank[i+1] &&
                     (w_scr_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      end
    end
    w_blank[0] = 1'b0;
  end

  assign blank_mask = blank_q;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    bin_d      = bin_q;
    count_d    = count_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CONV;
          scratch_d  = '0;
          bin_d      = w_clamped;
          count_d    = '0;
          ovf_pend_d = w_ovf_in;
        end
      end

      S_CONV: begin
        busy      = 1'b1;
        scratch_d = w_scr_shift;
        bin_d     = w_bin_shift;
        count_d   = count_q + CW'(1);
        // Results are loaded on the final shift so that they are already
        // valid during the done cycle.
        if (w_last) begin
          state_d = S_DONE;
          bcd_d   = w_scr_shift;
          ovf_d   = ovf_pend_q;
`ifdef BCD_BLANK_EN
          blank_d = w_blank;
`endif
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d    = S_CONV;
          scratch_d  = '0;
          bin_d      = w_clamped;
          count_d    = '0;
          ovf_pend_d = w_ovf_in;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scratch_q  <= '0;
      bin_q      <= '0;
      count_q    <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      bin_q      <= bin_d;
      count_q    <= count_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule : freq_bcd_converter
`default_nettype wire

// File: tb/tb_freq_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_bcd_converter
// Description : Self-checking bench for freq_bcd_converter. A transaction
//               level model predicts busy/done/bcd_out/overflow each cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_bcd_converter;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = 16'd0;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;
`ifdef BCD_BLANK_EN
  logic [3:0]  blank_mask;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  freq_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow)
`ifdef BCD_BLANK_EN
    ,
    .blank_mask(blank_mask)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of the saturated value, by plain division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int c;
    c = (v > MAXV) ? MAXV : v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(c % 10);
      c = c / 10;
    end
    return r;
  endfunction

  // Bit i (i>=1) set when the value has fewer than i+1 decimal digits.
  function automatic logic [3:0] to_blank(input int v);
    logic [3:0] m;
    int c;
    int p;
    c = (v > MAXV) ? MAXV : v;
    m = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      m[i] = (c < p);
      p = p * 10;
    end
    return m;
  endfunction

  // Transaction-level model: a captured value takes BIN_W cycles, then its
  // result is visible with done for one cycle, during which a new request
  // may be accepted.
  int          m_cnt = 0;
  int          m_val = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  logic [3:0]  m_blank = 4'b1110;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt   = 0;
      m_done  = 1'b0;
      m_bcd   = '0;
      m_ovf   = 1'b0;
      m_blank = 4'b1110;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done  = 1'b1;
          m_bcd   = to_bcd(m_val);
          m_ovf   = (m_val > MAXV);
          m_blank = to_blank(m_val);
        end
      end else if (start) begin
        m_val = int'(bin_in);
        m_cnt = BIN_W;
      end
    end
    #1;
    chk("m_busy", 32'(busy), 32'(m_cnt > 0));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_bcd", 32'(bcd_out), 32'(m_bcd));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
`ifdef BCD_BLANK_EN
    chk("m_blank", 32'(blank_mask), 32'(m_blank));
`endif
  end

  // Single request; checks latency, busy length and the literal result.
  task automatic run_one(input logic [15:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int k;
    int nbusy;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    k = 0;
    nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_cycle"}, 32'(k + 1), 32'd17);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd16);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk);
  endtask

  initial begin
    int k;
    int ndone;
    logic [15:0] v;

    // Reset for two cycles.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", 32'(blank_mask), 32'b1110);
`endif
    reset = 1'b0;
    @(negedge clk);

    run_one(16'd1234,  16'h1234, 1'b0, "v1234");
    run_one(16'd2047,  16'h2047, 1'b0, "v2047");
    run_one(16'd0,     16'h0000, 1'b0, "v0");
    run_one(16'd12000, 16'h9999, 1'b1, "v12000");
    run_one(16'd9999,  16'h9999, 1'b0, "v9999");
    run_one(16'd10000, 16'h9999, 1'b1, "v10000");
    run_one(16'd65535, 16'h9999, 1'b1, "v65535");
`ifdef BCD_BLANK_EN
    run_one(16'd7, 16'h0007, 1'b0, "v7");
    chk("blank7", 32'(blank_mask), 32'b1110);
    run_one(16'd305, 16'h0305, 1'b0, "v305");
    chk("blank305", 32'(blank_mask), 32'b1000);
`endif

    // Start held; bin_in changes mid-conversion, then back-to-back request.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd5;
    @(negedge clk);
    bin_in = 16'd42;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("hold_cycle", 32'(k + 1), 32'd17);
    chk("hold_bcd", 32'(bcd_out), 32'h0005);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    start = 1'b0;
    chk("b2b_cycles", 32'(k), 32'd17);
    chk("b2b_bcd", 32'(bcd_out), 32'h0042);
    @(negedge clk);

    // Reset during the 8th conversion cycle aborts without a done pulse.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd777;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h0000);
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Randomized requests: random gaps, random hold lengths, bin_in churn.
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 99));
        1:       v = 16'($urandom_range(9990, 10010));
        default: v = 16'($urandom);
      endcase
      start  = 1'b1;
      bin_in = v;
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        bin_in = 16'($urandom);
      end
      start = 1'b0;
      repeat (18) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_freq_bcd_converter
`default_nettype wire
